// File: rtl/lmon_pkg.sv
// Shared types for the traffic-light monitor: light codes, phases, FSM states.
package lmon_pkg;

  typedef enum logic [1:0] {
    L_GREEN  = 2'b00,
    L_YELLOW = 2'b01,
    L_RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    PH_AG = 2'b00,
    PH_AY = 2'b01,
    PH_BG = 2'b10,
    PH_BY = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_AG   = 3'd1,
    S_AY   = 3'd2,
    S_BG   = 3'd3,
    S_BY   = 3'd4
  } state_t;

  function automatic state_t to_state(phase_t p);
    unique case (p)
      PH_AG:   return S_AG;
      PH_AY:   return S_AY;
      PH_BG:   return S_BG;
      default: return S_BY;
    endcase
  endfunction

  function automatic phase_t to_phase(state_t s);
    unique case (s)
      S_AY:    return PH_AY;
      S_BG:    return PH_BG;
      S_BY:    return PH_BY;
      default: return PH_AG;
    endcase
  endfunction

  // Allowed successors of a locked state; yellow may never repeat.
  function automatic logic succ_ok(state_t s, phase_t p);
    unique case (s)
      S_AG:    return (p == PH_AG) || (p == PH_AY);
      S_AY:    return (p == PH_BG);
      S_BG:    return (p == PH_BG) || (p == PH_BY);
      S_BY:    return (p == PH_AG);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lmon_decode.sv
// Maps the two street light codes onto a legal flag and a phase.
module lmon_decode
  import lmon_pkg::*;
(
  input  logic [1:0] la,
  input  logic [1:0] lb,
  output logic       legal,
  output phase_t     phase
);

  always_comb begin
    legal = 1'b1;
    phase = PH_AG;
    unique case (1'b1)
      (la == L_GREEN)  && (lb == L_RED):    phase = PH_AG;
      (la == L_YELLOW) && (lb == L_RED):    phase = PH_AY;
      (la == L_RED)    && (lb == L_GREEN):  phase = PH_BG;
      (la == L_RED)    && (lb == L_YELLOW): phase = PH_BY;
      default:                              legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/light_monitor.sv
// Tracks a two-street traffic light, checking phase order and dwell.
// Build with LMON_TIMEOUT_EN to add the green dwell timeout check.
module light_monitor
  import lmon_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_GREEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  input  logic             clr,
  output logic             valid,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycles,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_timeout,
  output logic             err_any
);

  logic   dec_legal;
  phase_t dec_phase;

  lmon_decode u_decode (
    .la    (La),
    .lb    (Lb),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] dwell_inc;
  logic             err_ill_q, err_ill_d;
  logic             err_seq_q, err_seq_d;
  logic             new_ill, new_seq, hold_green;
  state_t           obs_state;

  assign obs_state = to_state(dec_phase);
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SYNC;
      dwell_q   <= '0;
      cycles_q  <= '0;
      err_ill_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      cycles_q  <= cycles_d;
      err_ill_q <= err_ill_d;
      err_seq_q <= err_seq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    cycles_d   = cycles_q;
    new_ill    = 1'b0;
    new_seq    = 1'b0;
    hold_green = 1'b0;
    if (state_q == S_SYNC) begin
      dwell_d = '0;
      if (dec_legal) state_d = obs_state;
    end else if (!dec_legal) begin
      state_d = S_SYNC;
      dwell_d = '0;
      new_ill = 1'b1;
    end else if (succ_ok(state_q, dec_phase)) begin
      if (obs_state == state_q) begin
        dwell_d    = dwell_inc;
        hold_green = 1'b1;
      end else begin
        state_d = obs_state;
        dwell_d = '0;
        if (state_q == S_BY) cycles_d = cycles_q + CNT_W'(1);
      end
    end else begin
      // Out-of-order phase: flag it and trust what we now see.
      state_d = obs_state;
      dwell_d = '0;
      new_seq = 1'b1;
    end
    err_ill_d = (err_ill_q & ~clr) | new_ill;
    err_seq_d = (err_seq_q & ~clr) | new_seq;
  end

`ifdef LMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(MAX_GREEN - 1);

  logic err_tmo_q, err_tmo_d, new_tmo;

  // Equality on the growing dwell fires once per green episode.
  assign new_tmo   = hold_green && (dwell_q == TMO_LIM);
  assign err_tmo_d = (err_tmo_q & ~clr) | new_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_tmo_q <= 1'b0;
    else     err_tmo_q <= err_tmo_d;
  end

  assign err_timeout = err_tmo_q;
`else
  if (MAX_GREEN < 1) begin : g_max_green_unused
  end

  logic unused_hold;
  assign unused_hold = hold_green;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    valid       = (state_q != S_SYNC);
    phase       = to_phase(state_q);
    dwell       = dwell_q;
    cycles      = cycles_q;
    err_illegal = err_ill_q;
    err_seq     = err_seq_q;
    err_any     = err_ill_q | err_seq_q | err_timeout;
  end

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: lock, order errors, clear, timeout, reset.
module tb_light_monitor;

  localparam int CNT_W = 8;

  localparam logic [3:0] P_AG  = 4'b0010;
  localparam logic [3:0] P_AY  = 4'b0110;
  localparam logic [3:0] P_BG  = 4'b1000;
  localparam logic [3:0] P_BY  = 4'b1001;
  localparam logic [3:0] P_ILL = 4'b1110;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       La = 2'b00;
  logic [1:0]       Lb = 2'b10;
  logic             clr = 1'b0;
  logic             valid;
  logic [1:0]       phase;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] cycles;
  logic             err_illegal;
  logic             err_seq;
  logic             err_timeout;
  logic             err_any;

  int n_chk  = 0;
  int n_fail = 0;

  light_monitor #(.CNT_W(CNT_W), .MAX_GREEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .La          (La),
    .Lb          (Lb),
    .clr         (clr),
    .valid       (valid),
    .phase       (phase),
    .dwell       (dwell),
    .cycles      (cycles),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_timeout (err_timeout),
    .err_any     (err_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] pair, input logic c);
    {La, Lb} = pair;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] ph, input logic [7:0] dw);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".dwell"}, 32'(dwell), 32'(dw));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 1'b0, 2'b00, 8'd0);
    chk("rst.cycles", 32'(cycles), 32'd0);
    chk("rst.err_any", 32'(err_any), 32'd0);
    rst = 1'b0;

    step(P_AG, 1'b0); chk_out("lock.ag0", 1'b1, 2'b00, 8'd0);
    step(P_AG, 1'b0); chk_out("lock.ag1", 1'b1, 2'b00, 8'd1);
    step(P_AG, 1'b0); chk_out("lock.ag2", 1'b1, 2'b00, 8'd2);
    step(P_AY, 1'b0); chk_out("lock.ay", 1'b1, 2'b01, 8'd0);
    step(P_BG, 1'b0); chk_out("lock.bg0", 1'b1, 2'b10, 8'd0);
    step(P_BG, 1'b0); chk_out("lock.bg1", 1'b1, 2'b10, 8'd1);
    step(P_BY, 1'b0); chk_out("lock.by", 1'b1, 2'b11, 8'd0);
    step(P_AG, 1'b0); chk_out("lock.wrap", 1'b1, 2'b00, 8'd0);
    chk("lock.cycles", 32'(cycles), 32'd1);
    chk("lock.err_any", 32'(err_any), 32'd0);

    step(P_AY, 1'b0);
    step(P_BG, 1'b0); chk_out("ill.pre", 1'b1, 2'b10, 8'd0);
    step(P_ILL, 1'b0); chk_out("ill.hit", 1'b0, 2'b00, 8'd0);
    chk("ill.flag", 32'(err_illegal), 32'd1);
    chk("ill.any", 32'(err_any), 32'd1);
    step(P_BG, 1'b0); chk_out("ill.relock", 1'b1, 2'b10, 8'd0);
    chk("ill.seq", 32'(err_seq), 32'd0);
    step(P_BG, 1'b1); chk_out("ill.clr", 1'b1, 2'b10, 8'd1);
    chk("ill.clr.flag", 32'(err_illegal), 32'd0);
    chk("ill.clr.any", 32'(err_any), 32'd0);

    step(P_BY, 1'b0);
    step(P_AG, 1'b0); chk("yel.cycles", 32'(cycles), 32'd2);
    step(P_AY, 1'b0); chk("yel.first", 32'(err_seq), 32'd0);
    step(P_AY, 1'b0); chk_out("yel.rep", 1'b1, 2'b01, 8'd0);
    chk("yel.flag", 32'(err_seq), 32'd1);
    step(P_BG, 1'b1); chk_out("yel.clr", 1'b1, 2'b10, 8'd0);
    chk("yel.clr.flag", 32'(err_seq), 32'd0);

    step(P_BY, 1'b0);
    step(P_AG, 1'b0); chk("skip.cycles0", 32'(cycles), 32'd3);
    step(P_BG, 1'b0); chk_out("skip.hit", 1'b1, 2'b10, 8'd0);
    chk("skip.flag", 32'(err_seq), 32'd1);
    chk("skip.cycles1", 32'(cycles), 32'd3);
    step(P_BG, 1'b1); chk("skip.clr", 32'(err_seq), 32'd0);
    step(P_BY, 1'b0);
    step(P_AG, 1'b0); chk("skip.cycles2", 32'(cycles), 32'd4);
    step(P_BY, 1'b1); chk_out("skip.clrhit", 1'b1, 2'b11, 8'd0);
    chk("skip.clrhit.flag", 32'(err_seq), 32'd1);
    chk("skip.clrhit.cyc", 32'(cycles), 32'd4);

    step(P_AG, 1'b1); chk("tmo.start", 32'(cycles), 32'd5);
    chk("tmo.clr", 32'(err_any), 32'd0);
    step(P_AG, 1'b0);
    step(P_AG, 1'b0);
    step(P_AG, 1'b0); chk_out("tmo.s4", 1'b1, 2'b00, 8'd3);
    chk("tmo.s4.flag", 32'(err_timeout), 32'd0);
    step(P_AG, 1'b0); chk_out("tmo.s5", 1'b1, 2'b00, 8'd4);
`ifdef LMON_TIMEOUT_EN
    chk("tmo.s5.flag", 32'(err_timeout), 32'd1);
`else
    chk("tmo.s5.flag", 32'(err_timeout), 32'd0);
`endif
    step(P_AG, 1'b0); chk_out("tmo.s6", 1'b1, 2'b00, 8'd5);
    step(P_AG, 1'b1); chk("tmo.clr2", 32'(err_timeout), 32'd0);
    step(P_AG, 1'b0); chk("tmo.once", 32'(err_timeout), 32'd0);
    chk("tmo.seq", 32'(err_seq), 32'd0);

    step(P_AY, 1'b0);
    repeat (6) step(P_BG, 1'b0);
    chk_out("mrst.pre", 1'b1, 2'b10, 8'd5);
    rst = 1'b1;
    #1;
    chk_out("mrst.async", 1'b0, 2'b00, 8'd0);
    chk("mrst.cycles", 32'(cycles), 32'd0);
    chk("mrst.err_any", 32'(err_any), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(P_ILL, 1'b0); chk_out("mrst.sync", 1'b0, 2'b00, 8'd0);
    chk("mrst.noerr", 32'(err_illegal), 32'd0);
    step(P_BY, 1'b0); chk_out("mrst.lock", 1'b1, 2'b11, 8'd0);
    step(P_AG, 1'b0); chk("mrst.cycles1", 32'(cycles), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
